// File: rtl/keypad_matrix_emulator.sv
// Passive 4x4 membrane keypad answering a column scanner: row lines are registered (1 cycle from col),
// with contact bounce at press and release; one command at a time, cmd_ready only while idle.
module keypad_matrix_emulator #(
    parameter int CLK_KHZ    = 25000,
    parameter int BOUNCE_CYC = 16,
    parameter int HOLD_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        col,
    output logic [3:0]        row,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold_ms,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [7:0]        press_count
);
    localparam int TW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
    localparam int BW = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_KHZ - 1);
    localparam logic [BW-1:0] BNC_LAST  = BW'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
    localparam bit            NO_BNC    = (BOUNCE_CYC == 0);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BNC,
        HOLD,
        REL_BNC,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        key_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bounce_cnt;
    logic              contact;
    logic              accept;
    logic              tick;
    logic [1:0]        key_row;
    logic [1:0]        key_col;
    logic [3:0]        row_nxt;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign done      = (state == DONE);
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (tick_cnt == TICK_LAST);

    always_comb begin
        state_nxt = state;
        contact   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = NO_BNC ? HOLD : PRESS_BNC;
            end
            PRESS_BNC: begin
                contact = ~bounce_cnt[0];
                if (abort)                         state_nxt = REL_BNC;
                else if (bounce_cnt == BNC_LAST)   state_nxt = HOLD;
            end
            HOLD: begin
                contact = 1'b1;
                if (abort || hold_cnt == '0)       state_nxt = REL_BNC;
            end
            REL_BNC: begin
                // With no bounce the counter never leaves 0, so this exits after one open cycle.
                contact = bounce_cnt[0];
                if (bounce_cnt == BNC_LAST)        state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit positions: col bit3 = C1 .. bit0 = C4, row bit3 = R1 .. bit0 = R4.
    always_comb begin
        {key_row, key_col} = 4'h0;
        case (key_q)
            4'h1: {key_row, key_col} = {2'd3, 2'd3};
            4'h2: {key_row, key_col} = {2'd3, 2'd2};
            4'h3: {key_row, key_col} = {2'd3, 2'd1};
            4'hA: {key_row, key_col} = {2'd3, 2'd0};
            4'h4: {key_row, key_col} = {2'd2, 2'd3};
            4'h5: {key_row, key_col} = {2'd2, 2'd2};
            4'h6: {key_row, key_col} = {2'd2, 2'd1};
            4'hB: {key_row, key_col} = {2'd2, 2'd0};
            4'h7: {key_row, key_col} = {2'd1, 2'd3};
            4'h8: {key_row, key_col} = {2'd1, 2'd2};
            4'h9: {key_row, key_col} = {2'd1, 2'd1};
            4'hC: {key_row, key_col} = {2'd1, 2'd0};
            4'h0: {key_row, key_col} = {2'd0, 2'd3};
            4'hF: {key_row, key_col} = {2'd0, 2'd2};
            4'hE: {key_row, key_col} = {2'd0, 2'd1};
            4'hD: {key_row, key_col} = {2'd0, 2'd0};
            default: {key_row, key_col} = 4'h0;
        endcase
    end

    always_comb begin
        row_nxt = 4'hF;
        if (contact) row_nxt[key_row] = col[key_col];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row         <= 4'hF;
            key_q       <= 4'h0;
            hold_cnt    <= '0;
            tick_cnt    <= '0;
            bounce_cnt  <= '0;
            press_count <= 8'd0;
        end else begin
            row        <= row_nxt;
            tick_cnt   <= (accept || tick) ? '0 : tick_cnt + 1'b1;
            bounce_cnt <= (state_nxt != state) ? '0 : bounce_cnt + 1'b1;
            if (accept) begin
                key_q    <= cmd_key;
                hold_cnt <= cmd_hold_ms;
            end else if (state == HOLD && tick && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (state == DONE) press_count <= press_count + 8'd1;
        end
    end
endmodule
